led_blink_sched: RTL and testbench

- Round-robin scheduler that shares one board LED between two requesters.
- Each requester asks for a blink burst: on-time, off-time, repeat count.
- Grants one requester at a time and drives the LED through the burst on a millisecond-class tick.
- Pulses a per-requester done flag, then re-arbitrates. Sits between status/diagnostic logic and the LED pin.

---
 rtl/led_blink_sched_if.sv | 38 +++
 rtl/led_blink_sched.sv | 206 ++++++++++++++++++++
 tb/tb_led_blink_sched.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/led_blink_sched_if.sv
// Request/grant/done bundle between two blink requesters and the shared-LED scheduler.
// The requester side (master) drives req/on/off/cnt; the scheduler side (slave) drives the rest.
interface led_blink_sched_if #(
    parameter int TW = 8,
    parameter int CW = 4
);
    logic          req0;
    logic [TW-1:0] on0;
    logic [TW-1:0] off0;
    logic [CW-1:0] cnt0;
    logic          gnt0;
    logic          done0;

    logic          req1;
    logic [TW-1:0] on1;
    logic [TW-1:0] off1;
    logic [CW-1:0] cnt1;
    logic          gnt1;
    logic          done1;

    logic          busy;
    logic          owner;
    logic          led;

    modport master (
        output req0, on0, off0, cnt0,
        output req1, on1, off1, cnt1,
        input  gnt0, done0, gnt1, done1,
        input  busy, owner, led
    );

    modport slave (
        input  req0, on0, off0, cnt0,
        input  req1, on1, off1, cnt1,
        output gnt0, done0, gnt1, done1,
        output busy, owner, led
    );
endinterface

// File: rtl/led_blink_sched.sv
// Round-robin scheduler sharing one LED between two blink-burst requesters.
// The FSM runs one cycle ahead of the registered outputs, so led/busy/done line up with the visible grant.
module led_blink_sched #(
    parameter int TICK_DIV = 10_000,
    parameter int TW       = 8,
    parameter int CW       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    led_blink_sched_if.slave  bus
);

    localparam int TKW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TKW-1:0] TICK_MAX  = TKW'(TICK_DIV - 1);
    localparam logic [TKW-1:0] TICK_ZERO = {TKW{1'b0}};
    localparam logic [TKW-1:0] TICK_ONE  = {{(TKW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0]  TIME_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0]  TIME_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    // A zero field means "one unit", which keeps every countdown non-empty.
    function automatic logic [TW-1:0] clamp_time(input logic [TW-1:0] v);
        clamp_time = (v == TIME_ZERO) ? TIME_ONE : v;
    endfunction

    function automatic logic [CW-1:0] clamp_cnt(input logic [CW-1:0] v);
        clamp_cnt = (v == CNT_ZERO) ? CNT_ONE : v;
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [TKW-1:0]  tick_r;
    logic [TW-1:0]   timer_r;
    logic [CW-1:0]   blink_r;
    logic [TW-1:0]   on_r;
    logic [TW-1:0]   off_r;
    logic [CW-1:0]   cnt_r;
    logic            ptr_r;
    logic            owner_r;
    logic            gnt0_r;
    logic            gnt1_r;
    logic            done0_r;
    logic            done1_r;
    logic            busy_r;
    logic            led_r;

    logic            tick_wrap_s;
    logic            unit_end_s;
    logic            grant_s;
    logic            win_s;
    logic            load_off_s;
    logic            reload_on_s;
    logic            finish_s;
    logic [TW-1:0]   on_sel_s;
    logic [TW-1:0]   off_sel_s;
    logic [CW-1:0]   cnt_sel_s;

    assign tick_wrap_s = (tick_r == TICK_MAX);
    assign unit_end_s  = tick_wrap_s && (timer_r == TIME_ONE);

    // Next-state logic and arbitration; busy_r gates arbitration so IDLE is visible for a cycle after done.
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        win_s       = 1'b0;
        load_off_s  = 1'b0;
        reload_on_s = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!busy_r && (bus.req0 || bus.req1)) begin
                    grant_s     = 1'b1;
                    state_nxt_s = ST_ON;
                    if (bus.req0 && bus.req1) begin
                        win_s = ~ptr_r;
                    end else begin
                        win_s = bus.req1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ON: begin
                if (unit_end_s) begin
                    load_off_s  = 1'b1;
                    state_nxt_s = ST_OFF;
                end else begin
                    state_nxt_s = ST_ON;
                end
            end
            ST_OFF: begin
                if (unit_end_s) begin
                    if (blink_r < (cnt_r - CNT_ONE)) begin
                        reload_on_s = 1'b1;
                        state_nxt_s = ST_ON;
                    end else begin
                        finish_s    = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_OFF;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Field selection for the arbitration winner.
    always_comb begin
        on_sel_s  = bus.on0;
        off_sel_s = bus.off0;
        cnt_sel_s = bus.cnt0;
        if (win_s) begin
            on_sel_s  = bus.on1;
            off_sel_s = bus.off1;
            cnt_sel_s = bus.cnt1;
        end else begin
            on_sel_s  = bus.on0;
            off_sel_s = bus.off0;
            cnt_sel_s = bus.cnt0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Burst timing datapath: tick prescaler, per-phase unit timer, blink counter and latched fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_r  <= TICK_ZERO;
            timer_r <= TIME_ZERO;
            blink_r <= CNT_ZERO;
            on_r    <= TIME_ZERO;
            off_r   <= TIME_ZERO;
            cnt_r   <= CNT_ZERO;
            ptr_r   <= 1'b1;
            owner_r <= 1'b0;
        end else if (grant_s) begin
            tick_r  <= TICK_ZERO;
            timer_r <= clamp_time(on_sel_s);
            blink_r <= CNT_ZERO;
            on_r    <= clamp_time(on_sel_s);
            off_r   <= clamp_time(off_sel_s);
            cnt_r   <= clamp_cnt(cnt_sel_s);
            ptr_r   <= win_s;
            owner_r <= win_s;
        end else if (state_r != ST_IDLE) begin
            tick_r <= tick_wrap_s ? TICK_ZERO : (tick_r + TICK_ONE);
            if (load_off_s) begin
                timer_r <= off_r;
            end else if (reload_on_s) begin
                timer_r <= on_r;
            end else if (tick_wrap_s) begin
                timer_r <= timer_r - TIME_ONE;
            end
            if (reload_on_s) begin
                blink_r <= blink_r + CNT_ONE;
            end else if (finish_s) begin
                blink_r <= CNT_ZERO;
            end
        end
    end

    // Registered outputs, one cycle behind the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            done0_r <= 1'b0;
            done1_r <= 1'b0;
            busy_r  <= 1'b0;
            led_r   <= 1'b0;
        end else begin
            gnt0_r  <= grant_s && !win_s;
            gnt1_r  <= grant_s && win_s;
            done0_r <= finish_s && !owner_r;
            done1_r <= finish_s && owner_r;
            busy_r  <= (state_r != ST_IDLE);
            led_r   <= (state_r == ST_ON);
        end
    end

    assign bus.gnt0  = gnt0_r;
    assign bus.gnt1  = gnt1_r;
    assign bus.done0 = done0_r;
    assign bus.done1 = done1_r;
    assign bus.busy  = busy_r;
    assign bus.owner = owner_r;
    assign bus.led   = led_r;

endmodule

// File: tb/tb_led_blink_sched.sv
// Self-checking bench for led_blink_sched: directed scenarios plus randomized bursts,
// checked cycle by cycle against a burst-level reference model.
module tb_led_blink_sched;

    localparam int TD = 4;
    localparam int TW = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    led_blink_sched_if #(.TW(TW), .CW(CW)) bus ();

    led_blink_sched #(.TICK_DIV(TD), .TW(TW), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int ptr_m  = 1;

    logic          r    [2];
    logic [TW-1:0] f_on [2];
    logic [TW-1:0] f_off[2];
    logic [CW-1:0] f_cnt[2];

    assign bus.req0 = r[0];
    assign bus.on0  = f_on[0];
    assign bus.off0 = f_off[0];
    assign bus.cnt0 = f_cnt[0];
    assign bus.req1 = r[1];
    assign bus.on1  = f_on[1];
    assign bus.off1 = f_off[1];
    assign bus.cnt1 = f_cnt[1];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_led"},   bus.led,   0);
        chk({tag, "_busy"},  bus.busy,  0);
        chk({tag, "_gnt0"},  bus.gnt0,  0);
        chk({tag, "_gnt1"},  bus.gnt1,  0);
        chk({tag, "_done0"}, bus.done0, 0);
        chk({tag, "_done1"}, bus.done1, 0);
        chk({tag, "_owner"}, bus.owner, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        r[0]  = 1'b0;
        r[1]  = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;
        ptr_m = 1;
        @(negedge clk);
    endtask

    // Wait for the next grant; the winner and latched fields come from the arbitration rules.
    task automatic expect_grant(input int exp_w, output int w, output int eon, output int eoff, output int ecnt);
        int  ew;
        int  k;
        bit  seen;
        ew   = (r[0] && r[1]) ? ((ptr_m == 0) ? 1 : 0) : (r[1] ? 1 : 0);
        eon  = eff(int'(f_on[ew]));
        eoff = eff(int'(f_off[ew]));
        ecnt = eff(int'(f_cnt[ew]));
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 300) begin
            @(negedge clk);
            k++;
            chk("busy_before_gnt", bus.busy, 0);
            if (bus.gnt0 || bus.gnt1) seen = 1'b1;
        end
        chk("gnt_seen", seen, 1);
        if (exp_w > 0) chk("gnt_latency", k, exp_w);
        chk("gnt_who", {bus.gnt1, bus.gnt0}, (ew == 1) ? 2 : 1);
        chk("owner_at_gnt", bus.owner, ew);
        chk("led_at_gnt", bus.led, 0);
        ptr_m = ew;
        w     = ew;
    endtask

    // Expected LED waveform built from on/off/cnt: cnt repeats of on*TD lit then off*TD dark.
    task automatic run_burst(input int w, input int eon, input int eoff, input int ecnt);
        bit q[$];
        int n;
        for (int b = 0; b < ecnt; b++) begin
            for (int i = 0; i < eon * TD; i++)  q.push_back(1'b1);
            for (int i = 0; i < eoff * TD; i++) q.push_back(1'b0);
        end
        n = q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("led",        bus.led,  q[i]);
            chk("busy",       bus.busy, 1);
            chk("done_mine",  (w == 1) ? bus.done1 : bus.done0, (i == n - 1) ? 1 : 0);
            chk("done_other", (w == 1) ? bus.done0 : bus.done1, 0);
            chk("gnt_in_burst", bus.gnt0 | bus.gnt1, 0);
            chk("owner_hold", bus.owner, w);
        end
    endtask

    initial begin
        int w, eon, eoff, ecnt, gap, pat;
        f_on[0] = '0; f_off[0] = '0; f_cnt[0] = '0;
        f_on[1] = '0; f_off[1] = '0; f_cnt[1] = '0;
        do_reset();

        // Single request, 2/3/2 -> 40-cycle burst
        f_on[0] = 8'd2; f_off[0] = 8'd3; f_cnt[0] = 4'd2;
        r[0] = 1'b1;
        expect_grant(1, w, eon, eoff, ecnt);
        chk("single_winner", w, 0);
        r[0] = 1'b0;
        run_burst(w, eon, eoff, ecnt);
        @(negedge clk);
        chk("post_done_busy", bus.busy, 0);
        chk("post_done_gnt", bus.gnt0 | bus.gnt1, 0);

        // Tie after reset: 0 first, then 1 exactly two cycles after done0
        do_reset();
        f_on[1] = 8'd1; f_off[1] = 8'd2; f_cnt[1] = 4'd2;
        r[0] = 1'b1; r[1] = 1'b1;
        expect_grant(1, w, eon, eoff, ecnt);
        chk("tie_first", w, 0);
        r[0] = 1'b0;
        run_burst(w, eon, eoff, ecnt);
        expect_grant(2, w, eon, eoff, ecnt);
        chk("tie_second", w, 1);
        r[1] = 1'b0;
        run_burst(w, eon, eoff, ecnt);

        // Round-robin with both requests held for four bursts
        for (int i = 0; i < 2; i++) begin
            f_on[i] = 8'($urandom_range(1, 3)); f_off[i] = 8'($urandom_range(1, 3)); f_cnt[i] = 4'($urandom_range(1, 2));
        end
        r[0] = 1'b1; r[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_grant(2, w, eon, eoff, ecnt);
            chk("rr_order", w, i % 2);
            f_on[w] = 8'($urandom_range(0, 3)); f_off[w] = 8'($urandom_range(0, 3)); f_cnt[w] = 4'($urandom_range(0, 2));
            if (i == 3) begin
                r[0] = 1'b0; r[1] = 1'b0;
            end
            run_burst(w, eon, eoff, ecnt);
        end

        // Zero fields are treated as 1/1/1
        @(negedge clk);
        f_on[1] = 8'd0; f_off[1] = 8'd0; f_cnt[1] = 4'd0;
        r[1] = 1'b1;
        expect_grant(1, w, eon, eoff, ecnt);
        chk("zero_winner", w, 1);
        r[1] = 1'b0;
        run_burst(w, 1, 1, 1);

        // Field change after grant has no effect
        repeat (2) @(negedge clk);
        f_on[0] = 8'd2; f_off[0] = 8'd1; f_cnt[0] = 4'd1;
        r[0] = 1'b1;
        expect_grant(1, w, eon, eoff, ecnt);
        r[0] = 1'b0;
        f_on[0] = 8'd7;
        run_burst(w, 2, 1, 1);

        // Randomized requests and fields
        for (int it = 0; it < 8; it++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                f_on[i] = 8'($urandom_range(0, 3)); f_off[i] = 8'($urandom_range(0, 3)); f_cnt[i] = 4'($urandom_range(0, 3));
            end
            pat = $urandom_range(1, 3);
            r[0] = pat[0]; r[1] = pat[1];
            expect_grant((gap == 0) ? 2 : 1, w, eon, eoff, ecnt);
            r[0] = 1'b0; r[1] = 1'b0;
            run_burst(w, eon, eoff, ecnt);
        end

        // Reset in the middle of an ON phase
        @(negedge clk);
        f_on[0] = 8'd3; f_off[0] = 8'd1; f_cnt[0] = 4'd1;
        r[0] = 1'b1;
        expect_grant(1, w, eon, eoff, ecnt);
        r[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_abort_led", bus.led, 1);
        chk("pre_abort_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check_quiet("abort");
        @(negedge clk);
        chk("abort_done0", bus.done0, 0);
        rst_n = 1'b1;
        ptr_m = 1;
        f_on[1] = 8'd1; f_off[1] = 8'd1; f_cnt[1] = 4'd1;
        r[0] = 1'b1; r[1] = 1'b1;
        expect_grant(1, w, eon, eoff, ecnt);
        chk("post_reset_tie", w, 0);
        r[0] = 1'b0; r[1] = 1'b0;
        run_burst(w, eon, eoff, ecnt);
        // Requester 1 withdrew before its grant, so nothing more is served
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("dropped_req_gnt", bus.gnt0 | bus.gnt1, 0);
            chk("dropped_req_busy", bus.busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
